perf_event_ctrl: RTL and testbench
==================================

# perf_event_ctrl

Measurement-window controller for the MPU's event counters. It owns a bank of `N_EVT` edge counters and sequences them through arm, count and drain phases. Each counter counts the selected edge of one event line, but only during a programmed window of clock cycles. When the window closes, the block reads the results out one record at a time over a valid/ready port. It sits between the MPU's status/handshake signals and the host-visible debug/readout path.

## Interface
Parameters:
- `N_EVT`, default 4: number of event lines and counters (1..16).
- `CNT_W`, default 8: counter width in bits.
- `WIN_W`, default 16: window length register width.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `evt`  in  N_EVT: event lines, synchronous to `clk`.
- `edge_sel`  in  N_EVT: per event, 0 = count rising edges, 1 = count falling edges. Sampled at `start`.
- `start`  in  1: request a measurement. Accepted only in IDLE.
- `window`  in  WIN_W: window length in cycles. Sampled at `start`.
- `abort`  in  1: cancel the current operation from any state.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when the last record is accepted.
- `rd_valid`  out  1: a readout record is presented.
- `rd_ready`  in  1: the consumer accepts the record.
- `rd_idx`  out  $clog2(N_EVT) (min 1): event index of the record.
- `rd_data`  out  CNT_W: count value of the record.

## Operation
- FSM states: IDLE, ARM, COUNT, DRAIN.
- IDLE -> ARM when `start`=1. On that edge, `window` and `edge_sel` are latched. `start` in any other state is ignored.
- ARM (1 cycle): all counters are cleared and the window down-counter is loaded.
  - ARM -> COUNT if the latched window is nonzero.
  - ARM -> DRAIN if the latched window is 0; all records then read 0.
- COUNT lasts exactly `window` cycles, then goes to DRAIN.
- Edge detection: each event has a `last` register that is updated every cycle in every state.
  - Rising edge: `evt & ~last`. Falling edge: `~evt & last`.
  - An edge increments its counter only if it is detected in a COUNT cycle.
  - No spurious edge is generated at ARM, because `last` is always current.
- Counters saturate at all-ones (see Configuration).
- DRAIN presents records for idx 0 .. N_EVT-1 in order.
  - `rd_data` and `rd_idx` are held stable while `rd_valid`=1 and `rd_ready`=0.
  - The index advances on `rd_valid & rd_ready`.
  - Acceptance of idx N_EVT-1 pulses `done` and returns to IDLE.
- `abort`=1 forces the next state to IDLE from any state and deasserts `rd_valid` next cycle. No `done` pulse is issued. Counter contents are don't-care after an abort.
- Simultaneous `abort` and `start` in IDLE: abort wins, and the FSM stays in IDLE.
- Reset values: FSM=IDLE, `busy`=0, `done`=0, `rd_valid`=0, `rd_idx`=0, `rd_data`=0, counters=0, `last`=0.

## Timing
- `start` is seen at edge T0.
- ARM occupies cycle T0+1.
- COUNT occupies cycles T0+2 .. T0+1+W.
- `rd_valid` rises at T0+2+W, or at T0+2 when W=0.
- An edge present on `evt` during cycle T0+1+W is counted. An edge in the first DRAIN cycle is not.
- `busy` rises in the cycle after the `start` edge.
- `busy` falls in the same cycle that `done` pulses: the cycle after the last handshake.
- With `rd_ready` held at 1, the drain takes N_EVT cycles.
- Total latency from `start` to `done` is 2 + W + N_EVT cycles.
- `rd_data` is registered, not combinational from `evt`.

## Configuration
- Macro: `PERF_EVT_SAT_EN`.
- Defined: counters saturate at 2^CNT_W-1 and stay there until the next ARM.
- Undefined: counters wrap modulo 2^CNT_W.

## Structure
- Shared package `mpu_perf_pkg` holds:
  - the FSM state typedef (`perf_state_t`: IDLE, ARM, COUNT, DRAIN);
  - the edge-select encoding constants `EDGE_RISE`=0 and `EDGE_FALL`=1.
- One sub-module, `evt_edge_counter`, instantiated N_EVT times.
  - Inputs: `clk`, `rst_n`, `sig`, `edge_sel`, `en`, `clr`.
  - Output: `cnt[CNT_W-1:0]`.
  - Contains the `last` register, the edge detection and the saturation logic.
- The FSM, window down-counter, readout mux and handshake live in the top level.

## Test plan
- Basic count:
  - Stimulus: N_EVT=4, W=10; evt[0] toggles every cycle; evt[1] has 3 rising pulses; evt[2]=0; evt[3] is constant 1.
  - Required response: records read 5, 3, 0, 0, with `done` at T0+16 when `rd_ready`=1.
- Falling edge:
  - Stimulus: `edge_sel[1]`=1, with 2 pulses on evt[1].
  - Required response: record 1 = 2. An edge landing on the last COUNT cycle is counted; one on the first DRAIN cycle is not.
- Saturation:
  - Stimulus: CNT_W=8, W=600, evt[0] toggling.
  - Required response: record 0 = 255 with `PERF_EVT_SAT_EN` defined, and 300 mod 256 = 44 without it.
- Backpressure:
  - Stimulus: `rd_ready` held low 5 cycles on each record.
  - Required response: `rd_idx` and `rd_data` stay stable while stalled; the 4 records arrive in order; exactly one `done` pulse.
- Window 0 and ignored start:
  - Stimulus: W=0, then a second `start` pulsed during DRAIN.
  - Required response: `rd_valid` at T0+2, all records 0, and the second `start` is ignored.
- Abort:
  - Stimulus: `abort` asserted mid-COUNT and again mid-DRAIN.
  - Required response: IDLE on the next cycle, `busy`=0, `rd_valid`=0, no `done`. A following `start` yields correct fresh counts.

Source files
------------

// File: rtl/mpu_perf_pkg.sv
// Shared types for the MPU event-counter measurement window: FSM state
// encoding and the per-event edge-select encoding.
package mpu_perf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        DRAIN = 2'd3
    } perf_state_t;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

endpackage

// File: rtl/evt_edge_counter.sv
// One event counter: tracks the previous sample of its event line, detects the
// selected edge and counts it while enabled. PERF_EVT_SAT_EN selects saturation.
module evt_edge_counter
    import mpu_perf_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig,
    input  logic             edge_sel,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic             last_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             edge_hit;

    // last_q follows sig in every state, so enabling the count never sees a stale edge.
    assign edge_hit = (edge_sel == EDGE_FALL) ? (~sig & last_q) : (sig & ~last_q);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && edge_hit) begin
`ifdef PERF_EVT_SAT_EN
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
`else
            cnt_d = cnt_q + CNT_W'(1);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            last_q <= sig;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/perf_event_ctrl.sv
// Measurement-window controller: arms a bank of edge counters, counts for a
// programmed window, then drains one record per handshake. Macro: PERF_EVT_SAT_EN.
module perf_event_ctrl
    import mpu_perf_pkg::*;
#(
    parameter int N_EVT = 4,
    parameter int CNT_W = 8,
    parameter int WIN_W = 16,
    localparam int IDX_W = (N_EVT > 1) ? $clog2(N_EVT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_EVT-1:0] evt,
    input  logic [N_EVT-1:0] edge_sel,
    input  logic             start,
    input  logic [WIN_W-1:0] window,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_data
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_EVT - 1);

    perf_state_t      state_q;
    logic [WIN_W-1:0] win_len_q;
    logic [WIN_W-1:0] win_q;
    logic [N_EVT-1:0] edge_sel_q;
    logic             busy_q;
    logic             done_q;
    logic             rd_valid_q;
    logic [IDX_W-1:0] rd_idx_q;

    logic             cnt_clr;
    logic             cnt_en;
    logic             rd_hs;
    logic [CNT_W-1:0] cnt_w [N_EVT];
    logic [CNT_W-1:0] rd_data_mux;

    assign cnt_clr = (state_q == ARM);
    assign cnt_en  = (state_q == COUNT);
    assign rd_hs   = rd_valid_q & rd_ready;

    genvar gi;
    generate
        for (gi = 0; gi < N_EVT; gi++) begin : g_cnt
            evt_edge_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk      (clk),
                .rst_n    (rst_n),
                .sig      (evt[gi]),
                .edge_sel (edge_sel_q[gi]),
                .en       (cnt_en),
                .clr      (cnt_clr),
                .cnt      (cnt_w[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            win_len_q  <= '0;
            win_q      <= '0;
            edge_sel_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_idx_q   <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q    <= IDLE;
                busy_q     <= 1'b0;
                rd_valid_q <= 1'b0;
                rd_idx_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            win_len_q  <= window;
                            edge_sel_q <= edge_sel;
                            busy_q     <= 1'b1;
                            state_q    <= ARM;
                        end
                    end
                    ARM: begin
                        win_q    <= win_len_q;
                        rd_idx_q <= '0;
                        if (win_len_q == '0) begin
                            state_q    <= DRAIN;
                            rd_valid_q <= 1'b1;
                        end else begin
                            state_q <= COUNT;
                        end
                    end
                    COUNT: begin
                        // win_q holds the COUNT cycles still left, including this one.
                        win_q <= win_q - WIN_W'(1);
                        if (win_q == WIN_W'(1)) begin
                            state_q    <= DRAIN;
                            rd_valid_q <= 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (rd_hs) begin
                            if (rd_idx_q == LAST_IDX) begin
                                state_q    <= IDLE;
                                rd_valid_q <= 1'b0;
                                busy_q     <= 1'b0;
                                done_q     <= 1'b1;
                                rd_idx_q   <= '0;
                            end else begin
                                rd_idx_q <= rd_idx_q + IDX_W'(1);
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // Counters only move in COUNT, so outside it this mux of registers is stable.
    always_comb begin
        rd_data_mux = '0;
        for (int i = 0; i < N_EVT; i++) begin
            if (rd_idx_q == IDX_W'(i)) begin
                rd_data_mux = cnt_w[i];
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_valid = rd_valid_q;
    assign rd_idx   = rd_idx_q;
    assign rd_data  = rd_data_mux;

endmodule

// File: tb/tb_perf_event_ctrl.sv
// Self-checking bench for perf_event_ctrl: directed scenarios plus random runs,
// checked against an edge-counting model of the measurement window.
module tb_perf_event_ctrl;

    localparam int N    = 4;
    localparam int CW   = 8;
    localparam int WW   = 16;
    localparam int MAXV = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  evt;
    logic [N-1:0]  edge_sel;
    logic          start;
    logic [WW-1:0] window;
    logic          abort;
    logic          busy;
    logic          done;
    logic          rd_valid;
    logic          rd_ready;
    logic [1:0]    rd_idx;
    logic [CW-1:0] rd_data;

    int checks = 0;
    int errors = 0;

    perf_event_ctrl #(
        .N_EVT (N),
        .CNT_W (CW),
        .WIN_W (WW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .evt      (evt),
        .edge_sel (edge_sel),
        .start    (start),
        .window   (window),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Event waveforms: 0 random, 1 basic-count pattern, 2 evt[0] toggling,
    // 3 edges placed on the last COUNT cycle (k=9) and first DRAIN cycle (k=10) for W=8.
    function automatic logic [N-1:0] gen(input int mode, input int k);
        logic [N-1:0] v;
        logic [31:0]  kk;
        kk = k;
        case (mode)
            1:       v = {1'b1, 1'b0, (k == 3 || k == 5 || k == 8), kk[0]};
            2:       v = {3'b000, kk[0]};
            3:       v = {(k == 10), (k == 9), (k == 3 || k == 8), (k >= 9)};
            default: v = N'($urandom);
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_val(input int c);
`ifdef PERF_EVT_SAT_EN
        return (c > MAXV) ? MAXV : c;
`else
        return c % (MAXV + 1);
`endif
    endfunction

    // One full measurement: start, window, drain with optional stalls per record.
    task automatic measure(input string name, input int w, input logic [N-1:0] esel,
                           input int mode, input int stall, input bit start_in_drain);
        int           cnt [N];
        logic [N-1:0] prev;
        logic [N-1:0] cur;
        int           k;
        bit           hit;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        cur      = gen(mode, 0);
        evt      = cur;
        prev     = cur;
        window   = WW'(w);
        edge_sel = esel;
        start    = 1'b1;
        rd_ready = 1'b0;
        for (k = 1; k <= w + 1; k++) begin
            tick();
            start = 1'b0;
            if (k == 1) chk({name, "_busy_rise"}, busy, 1);
            if (k == 1 || k == w + 1) chk({name, "_valid_low"}, rd_valid, 0);
            cur = gen(mode, k);
            evt = cur;
            if (k >= 2) begin
                for (int i = 0; i < N; i++) begin
                    hit = esel[i] ? (prev[i] & ~cur[i]) : (~prev[i] & cur[i]);
                    if (hit) cnt[i]++;
                end
            end
            prev = cur;
        end
        tick();
        k = w + 2;
        evt = gen(mode, k);
        if (start_in_drain) start = 1'b1;
        chk({name, "_valid_rise"}, rd_valid, 1);
        for (int idx = 0; idx < N; idx++) begin
            for (int s = 0; s < stall; s++) begin
                rd_ready = 1'b0;
                if (s == 0 || s == stall - 1) begin
                    chk({name, "_stall_valid"}, rd_valid, 1);
                    chk({name, "_stall_idx"}, rd_idx, idx);
                    chk({name, "_stall_data"}, rd_data, model_val(cnt[idx]));
                end
                tick();
                k++;
                evt   = gen(mode, k);
                start = 1'b0;
            end
            rd_ready = 1'b1;
            chk({name, "_valid"}, rd_valid, 1);
            chk({name, "_idx"}, rd_idx, idx);
            chk({name, "_data"}, rd_data, model_val(cnt[idx]));
            chk({name, "_no_early_done"}, done, 0);
            tick();
            k++;
            evt   = gen(mode, k);
            start = 1'b0;
        end
        rd_ready = 1'b0;
        chk({name, "_done"}, done, 1);
        chk({name, "_busy_fall"}, busy, 0);
        chk({name, "_valid_fall"}, rd_valid, 0);
        tick();
        chk({name, "_done_single"}, done, 0);
        chk({name, "_idle_after"}, busy, 0);
        $display("run %s W=%0d esel=%b counts=%0d,%0d,%0d,%0d", name, w, esel,
                 model_val(cnt[0]), model_val(cnt[1]), model_val(cnt[2]), model_val(cnt[3]));
    endtask

    initial begin
        rst_n    = 1'b0;
        evt      = '0;
        edge_sel = '0;
        start    = 1'b0;
        window   = '0;
        abort    = 1'b0;
        rd_ready = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_idx", rd_idx, 0);
        chk("rst_data", rd_data, 0);
        rst_n = 1'b1;
        tick();

        measure("basic", 10, 4'b0000, 1, 0, 1'b0);
        measure("fall", 8, 4'b0110, 3, 0, 1'b0);
        measure("sat", 600, 4'b0000, 2, 0, 1'b0);
        measure("bp", 7, 4'b1010, 0, 5, 1'b0);
        measure("w0", 0, 4'b0000, 0, 0, 1'b1);

        // Abort mid-COUNT.
        window = 20;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            evt = N'($urandom);
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_cnt_busy", busy, 0);
        chk("abort_cnt_valid", rd_valid, 0);
        chk("abort_cnt_done", done, 0);
        tick();
        chk("abort_cnt_done2", done, 0);
        chk("abort_cnt_busy2", busy, 0);
        $display("run abort_count");

        // Abort mid-DRAIN after one accepted record.
        window = 2;
        start  = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("abort_drn_valid_pre", rd_valid, 1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("abort_drn_idx_pre", rd_idx, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_drn_busy", busy, 0);
        chk("abort_drn_valid", rd_valid, 0);
        chk("abort_drn_done", done, 0);
        tick();
        chk("abort_drn_done2", done, 0);
        $display("run abort_drain");

        measure("fresh", 12, 4'b0011, 0, 0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            measure("rand", $urandom_range(0, 40), N'($urandom), 0, $urandom_range(0, 2), 1'b0);
        end

        // Abort wins over start in IDLE.
        window = 5;
        start  = 1'b1;
        abort  = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        tick();
        chk("start_abort_busy2", busy, 0);
        chk("start_abort_valid", rd_valid, 0);
        $display("run start_with_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
